// File: rtl/openmips_min_sopc.sv
// Minimal SOPC: a 5-stage MIPS-subset pipeline (logic and shift ops only)
// with a combinational instruction ROM and a 32-entry register file.

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Same-cycle write is bypassed so WB needs no separate forwarding path.
    always_comb begin
        rdata1 = 32'h0;
        if (raddr1 == 5'd0)                    rdata1 = 32'h0;
        else if (we && (waddr == raddr1))      rdata1 = wdata;
        else                                   rdata1 = regs[raddr1];
    end

    always_comb begin
        rdata2 = 32'h0;
        if (raddr2 == 5'd0)                    rdata2 = 32'h0;
        else if (we && (waddr == raddr2))      rdata2 = wdata;
        else                                   rdata2 = regs[raddr2];
    end
endmodule

module inst_rom #(
    parameter int INST_ROM_WORDS = 1024,
    parameter int AW             = $clog2(INST_ROM_WORDS)
) (
    input  logic          ce,
    input  logic [AW-1:0] addr,
    output logic [31:0]   inst
);
    logic [31:0] inst_mem [0:INST_ROM_WORDS-1];

    assign inst = ce ? inst_mem[addr] : 32'h0;
endmodule

module openmips #(
    parameter int INST_ROM_WORDS = 1024
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(INST_ROM_WORDS);

    typedef enum logic [2:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
    } aluop_e;

    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic [31:0] rom_inst;

    logic [31:0] if_id_inst_q;

    aluop_e      id_ex_aluop_q, id_ex_aluop_d;
    logic [31:0] id_ex_a_q, id_ex_a_d;
    logic [31:0] id_ex_b_q, id_ex_b_d;
    logic [4:0]  id_ex_wd_q, id_ex_wd_d;
    logic        id_ex_wreg_q, id_ex_wreg_d;

    logic [31:0] ex_wdata;

    logic [4:0]  ex_mem_wd_q;
    logic        ex_mem_wreg_q;
    logic [31:0] ex_mem_wdata_q;

    logic [4:0]  mem_wb_wd_q;
    logic        mem_wb_wreg_q;
    logic [31:0] mem_wb_wdata_q;

    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] rs_val, rt_val;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;

    inst_rom #(.INST_ROM_WORDS(INST_ROM_WORDS)) inst_rom0 (
        .ce   (ce_q),
        .addr (pc_q[AW+1:2]),
        .inst (rom_inst)
    );

    regfile regfile1 (
        .clk    (clk),
        .rst    (rst),
        .we     (mem_wb_wreg_q),
        .waddr  (mem_wb_wd_q),
        .wdata  (mem_wb_wdata_q),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // First edge out of reset only enables fetch; pc starts advancing after.
    assign pc_d = ce_q ? pc_q + 32'd4 : 32'h0;

    assign op    = if_id_inst_q[31:26];
    assign rs    = if_id_inst_q[25:21];
    assign rt    = if_id_inst_q[20:16];
    assign rd    = if_id_inst_q[15:11];
    assign sa    = if_id_inst_q[10:6];
    assign funct = if_id_inst_q[5:0];
    assign imm   = if_id_inst_q[15:0];

    // Operand forwarding: EX result wins over MEM, both over the regfile.
    always_comb begin
        rs_val = rf_rdata1;
        if (rs == 5'd0)                                  rs_val = 32'h0;
        else if (id_ex_wreg_q && (id_ex_wd_q == rs))     rs_val = ex_wdata;
        else if (ex_mem_wreg_q && (ex_mem_wd_q == rs))   rs_val = ex_mem_wdata_q;
    end

    always_comb begin
        rt_val = rf_rdata2;
        if (rt == 5'd0)                                  rt_val = 32'h0;
        else if (id_ex_wreg_q && (id_ex_wd_q == rt))     rt_val = ex_wdata;
        else if (ex_mem_wreg_q && (ex_mem_wd_q == rt))   rt_val = ex_mem_wdata_q;
    end

    always_comb begin
        id_ex_aluop_d = ALU_NOP;
        id_ex_a_d     = 32'h0;
        id_ex_b_d     = 32'h0;
        id_ex_wd_d    = 5'd0;
        id_ex_wreg_d  = 1'b0;
        if (op == 6'h00) begin
            id_ex_wd_d = rd;
            id_ex_b_d  = rt_val;
            id_ex_a_d  = rs_val;
            case (funct)
                6'h24: begin id_ex_aluop_d = ALU_AND; id_ex_wreg_d = 1'b1; end
                6'h25: begin id_ex_aluop_d = ALU_OR;  id_ex_wreg_d = 1'b1; end
                6'h26: begin id_ex_aluop_d = ALU_XOR; id_ex_wreg_d = 1'b1; end
                6'h27: begin id_ex_aluop_d = ALU_NOR; id_ex_wreg_d = 1'b1; end
                6'h04: begin id_ex_aluop_d = ALU_SLL; id_ex_wreg_d = 1'b1; end
                6'h06: begin id_ex_aluop_d = ALU_SRL; id_ex_wreg_d = 1'b1; end
                6'h07: begin id_ex_aluop_d = ALU_SRA; id_ex_wreg_d = 1'b1; end
                6'h00: begin id_ex_aluop_d = ALU_SLL; id_ex_a_d = {27'h0, sa}; id_ex_wreg_d = 1'b1; end
                6'h02: begin id_ex_aluop_d = ALU_SRL; id_ex_a_d = {27'h0, sa}; id_ex_wreg_d = 1'b1; end
                6'h03: begin id_ex_aluop_d = ALU_SRA; id_ex_a_d = {27'h0, sa}; id_ex_wreg_d = 1'b1; end
                default: id_ex_wreg_d = 1'b0;
            endcase
        end else begin
            id_ex_wd_d = rt;
            id_ex_a_d  = rs_val;
            id_ex_b_d  = {16'h0, imm};
            case (op)
                6'h0C: begin id_ex_aluop_d = ALU_AND; id_ex_wreg_d = 1'b1; end
                6'h0D: begin id_ex_aluop_d = ALU_OR;  id_ex_wreg_d = 1'b1; end
                6'h0E: begin id_ex_aluop_d = ALU_XOR; id_ex_wreg_d = 1'b1; end
                6'h0F: begin
                    id_ex_aluop_d = ALU_OR;
                    id_ex_a_d     = {imm, 16'h0};
                    id_ex_b_d     = 32'h0;
                    id_ex_wreg_d  = 1'b1;
                end
                default: id_ex_wreg_d = 1'b0;
            endcase
        end
        // Writes to $0 are dropped here so forwarding never matches $0.
        if (id_ex_wd_d == 5'd0) id_ex_wreg_d = 1'b0;
    end

    always_comb begin
        ex_wdata = 32'h0;
        case (id_ex_aluop_q)
            ALU_AND: ex_wdata = id_ex_a_q & id_ex_b_q;
            ALU_OR:  ex_wdata = id_ex_a_q | id_ex_b_q;
            ALU_XOR: ex_wdata = id_ex_a_q ^ id_ex_b_q;
            ALU_NOR: ex_wdata = ~(id_ex_a_q | id_ex_b_q);
            ALU_SLL: ex_wdata = id_ex_b_q << id_ex_a_q[4:0];
            ALU_SRL: ex_wdata = id_ex_b_q >> id_ex_a_q[4:0];
            ALU_SRA: ex_wdata = $unsigned($signed(id_ex_b_q) >>> id_ex_a_q[4:0]);
            default: ex_wdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= 32'h0;
            ce_q           <= 1'b0;
            if_id_inst_q   <= 32'h0;
            id_ex_aluop_q  <= ALU_NOP;
            id_ex_a_q      <= 32'h0;
            id_ex_b_q      <= 32'h0;
            id_ex_wd_q     <= 5'd0;
            id_ex_wreg_q   <= 1'b0;
            ex_mem_wd_q    <= 5'd0;
            ex_mem_wreg_q  <= 1'b0;
            ex_mem_wdata_q <= 32'h0;
            mem_wb_wd_q    <= 5'd0;
            mem_wb_wreg_q  <= 1'b0;
            mem_wb_wdata_q <= 32'h0;
        end else begin
            pc_q           <= pc_d;
            ce_q           <= 1'b1;
            if_id_inst_q   <= rom_inst;
            id_ex_aluop_q  <= id_ex_aluop_d;
            id_ex_a_q      <= id_ex_a_d;
            id_ex_b_q      <= id_ex_b_d;
            id_ex_wd_q     <= id_ex_wd_d;
            id_ex_wreg_q   <= id_ex_wreg_d;
            ex_mem_wd_q    <= id_ex_wd_q;
            ex_mem_wreg_q  <= id_ex_wreg_q;
            ex_mem_wdata_q <= ex_wdata;
            mem_wb_wd_q    <= ex_mem_wd_q;
            mem_wb_wreg_q  <= ex_mem_wreg_q;
            mem_wb_wdata_q <= ex_mem_wdata_q;
        end
    end
endmodule

module openmips_min_sopc #(
    parameter int INST_ROM_WORDS = 1024
) (
    input logic clk,
    input logic rst
);
    openmips #(.INST_ROM_WORDS(INST_ROM_WORDS)) openmips0 (
        .clk (clk),
        .rst (rst)
    );
endmodule

// File: tb/tb_openmips_min_sopc.sv
// Directed bench: runs the shift/logic program and watches $2/$5/$7/$8 retire
// cycle by cycle, then re-checks restart after a mid-run reset.

module tb_openmips_min_sopc;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] prog [0:15] = '{
        32'h3C020404,  // lui  $2,0x0404
        32'h34420404,  // ori  $2,$2,0x0404
        32'h34070007,  // ori  $7,$0,7
        32'h34050005,  // ori  $5,$0,5
        32'h34080008,  // ori  $8,$0,8
        32'h0000000F,  // sync
        32'h00021200,  // sll  $2,$2,8
        32'h00E21004,  // sllv $2,$2,$7
        32'h00021202,  // srl  $2,$2,8
        32'h00A21006,  // srlv $2,$2,$5
        32'h00000000,  // nop
        32'h000214C0,  // sll  $2,$2,19
        32'h00000040,  // ssnop
        32'h00021403,  // sra  $2,$2,16
        32'h01021007,  // srav $2,$2,$8
        32'h00000000
    };

    openmips_min_sopc #(.INST_ROM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int i = 0; i < 1024; i++) dut.openmips0.inst_rom0.inst_mem[i] = 32'h0;
        for (int i = 0; i < 16; i++)   dut.openmips0.inst_rom0.inst_mem[i] = prog[i];
        tick(3);
        check("rst_pc", dut.openmips0.pc_q, 32'h0);
        check("rst_ce", 32'(dut.openmips0.ce_q), 32'h0);
        check("rst_r2", dut.openmips0.regfile1.regs[2], 32'h0);

        rst = 1'b0;
        tick(1);                                       // edge 1
        check("e1_pc", dut.openmips0.pc_q, 32'h0);
        check("e1_ce", 32'(dut.openmips0.ce_q), 32'h1);
        tick(2);                                       // edge 3
        check("e3_pc", dut.openmips0.pc_q, 32'h8);
        tick(2);                                       // edge 5
        check("e5_r2_not_yet", dut.openmips0.regfile1.regs[2], 32'h0);
        tick(1);
        check("lui_r2", dut.openmips0.regfile1.regs[2], 32'h04040000);
        tick(1);
        check("ori_r2", dut.openmips0.regfile1.regs[2], 32'h04040404);
        tick(1);
        check("ori_r7", dut.openmips0.regfile1.regs[7], 32'h7);
        tick(1);
        check("ori_r5", dut.openmips0.regfile1.regs[5], 32'h5);
        tick(1);
        check("ori_r8", dut.openmips0.regfile1.regs[8], 32'h8);
        tick(1);
        check("sync_r2", dut.openmips0.regfile1.regs[2], 32'h04040404);
        tick(1);
        check("sll_r2", dut.openmips0.regfile1.regs[2], 32'h04040400);
        tick(1);
        check("sllv_r2", dut.openmips0.regfile1.regs[2], 32'h02020000);
        tick(1);
        check("srl_r2", dut.openmips0.regfile1.regs[2], 32'h00020200);
        tick(1);
        check("srlv_r2", dut.openmips0.regfile1.regs[2], 32'h00001010);
        tick(1);
        check("nop_r2", dut.openmips0.regfile1.regs[2], 32'h00001010);
        tick(1);
        check("sll19_r2", dut.openmips0.regfile1.regs[2], 32'h80800000);
        tick(1);
        check("ssnop_r2", dut.openmips0.regfile1.regs[2], 32'h80800000);
        tick(1);
        check("sra_r2", dut.openmips0.regfile1.regs[2], 32'hFFFF8080);
        tick(1);
        check("srav_r2", dut.openmips0.regfile1.regs[2], 32'hFFFFFF80);
        check("end_r5", dut.openmips0.regfile1.regs[5], 32'h5);
        check("end_r7", dut.openmips0.regfile1.regs[7], 32'h7);
        check("end_r8", dut.openmips0.regfile1.regs[8], 32'h8);
        check("end_r0", dut.openmips0.regfile1.regs[0], 32'h0);
        tick(2);
        check("tail_r2", dut.openmips0.regfile1.regs[2], 32'hFFFFFF80);

        rst = 1'b1;
        tick(2);
        check("mid_rst_r2", dut.openmips0.regfile1.regs[2], 32'h0);
        check("mid_rst_r7", dut.openmips0.regfile1.regs[7], 32'h0);
        check("mid_rst_pc", dut.openmips0.pc_q, 32'h0);
        rst = 1'b0;
        tick(5);
        check("re_e5_r2", dut.openmips0.regfile1.regs[2], 32'h0);
        check("re_e5_pc", dut.openmips0.pc_q, 32'h10);
        tick(1);
        check("re_lui_r2", dut.openmips0.regfile1.regs[2], 32'h04040000);
        tick(1);
        check("re_ori_r2", dut.openmips0.regfile1.regs[2], 32'h04040404);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
